// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates RV32 branch conditions, registers the resolved
// next PC behind a valid/ready handshake and trains a saturating-counter BHT on retire.
module branch_resolve_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CTR_BITS  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      funct3,
    input  logic            pred_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] next_pc,
    output logic            mispredict,
    output logic            illegal,
    input  logic [XLEN-1:0] query_pc,
    output logic            query_taken,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] bht [BHT_DEPTH];
    logic [IDX_W-1:0]    ret_idx;
    logic [IDX_W-1:0]    qidx;
    logic                accept;
    logic                retire;
    logic                eq;
    logic                lt;
    logic                ltu;
    logic                res_taken;
    logic                res_illegal;
    logic [XLEN-1:0]     target;
    logic [XLEN-1:0]     fallthru;
    logic                unused_qbits;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready && !flush;

    assign eq       = (rs1 == rs2);
    assign lt       = ($signed(rs1) < $signed(rs2));
    assign ltu      = (rs1 < rs2);
    assign target   = pc + imm;
    assign fallthru = pc + XLEN'(4);

    always_comb begin
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        case (funct3)
            3'b000:  res_taken = eq;
            3'b001:  res_taken = !eq;
            3'b100:  res_taken = lt;
            3'b101:  res_taken = !lt;
            3'b110:  res_taken = ltu;
            3'b111:  res_taken = !ltu;
            default: res_illegal = 1'b1;
        endcase
    end

    // Only the index bits of query_pc select an entry; the rest are intentionally ignored.
    assign qidx         = query_pc[IDX_W+1:2];
    assign query_taken  = bht[qidx][CTR_BITS-1];
    assign unused_qbits = ^{query_pc[XLEN-1:IDX_W+2], query_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            taken      <= 1'b0;
            next_pc    <= '0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
            ret_idx    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            taken      <= res_taken;
            next_pc    <= res_taken ? target : fallthru;
            mispredict <= !res_illegal && (res_taken != pred_in);
            illegal    <= res_illegal;
            ret_idx    <= pc[IDX_W+1:2];
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (retire && !illegal) begin
            if (taken) begin
                if (bht[ret_idx] != CTR_MAX) bht[ret_idx] <= bht[ret_idx] + 1'b1;
            end else begin
                if (bht[ret_idx] != '0) bht[ret_idx] <= bht[ret_idx] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (retire) begin
            if (!illegal)  stat_branches    <= stat_branches + 32'd1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus handshake, flush,
// reset and BHT saturation sequences checked against a small reference model.
module tb_branch_resolve_unit;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        pred;
        logic        e_taken;
        logic [31:0] e_npc;
        logic        e_mis;
        logic        e_ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        pred_in;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] next_pc;
    logic        mispredict;
    logic        illegal;
    logic [31:0] query_pc;
    logic        query_taken;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_cmp = 0;
    int n_bad = 0;
    int bht_m [16];
    int exp_br;
    int exp_mis;
    vec_t vecs [14];

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN(32),
        .BHT_DEPTH(16),
        .CTR_BITS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pc(pc),
        .rs1(rs1),
        .rs2(rs2),
        .imm(imm),
        .funct3(funct3),
        .pred_in(pred_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .taken(taken),
        .next_pc(next_pc),
        .mispredict(mispredict),
        .illegal(illegal),
        .query_pc(query_pc),
        .query_taken(query_taken),
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] p, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] im, input logic pr,
                                input logic et, input logic [31:0] en, input logic em, input logic ei);
        vec_t v;
        v.f3 = f3; v.pc = p; v.rs1 = a; v.rs2 = b; v.imm = im; v.pred = pr;
        v.e_taken = et; v.e_npc = en; v.e_mis = em; v.e_ill = ei;
        return v;
    endfunction

    function automatic int idx_of(input logic [31:0] p);
        return int'(p[5:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 1;
        exp_br  = 0;
        exp_mis = 0;
    endtask

    task automatic model_retire(input vec_t v);
        int i;
        if (!v.e_ill) begin
            i = idx_of(v.pc);
            if (v.e_taken) begin
                if (bht_m[i] < 3) bht_m[i]++;
            end else if (bht_m[i] > 0) begin
                bht_m[i]--;
            end
            exp_br++;
        end
        if (v.e_mis) exp_mis++;
    endtask

    task automatic drive(input vec_t v);
        pc = v.pc; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; funct3 = v.f3; pred_in = v.pred;
    endtask

    task automatic check_query(input string name, input logic [31:0] qpc);
        query_pc = qpc;
        #1;
        chk(name, query_taken, (bht_m[idx_of(qpc)] >= 2));
    endtask

    task automatic check_stats(input string name);
        chk({name, " stat_branches"}, stat_branches, exp_br);
        chk({name, " stat_mispredicts"}, stat_mispredicts, exp_mis);
    endtask

    // Single accept, one cycle of output, then retire with a read-before-write query.
    task automatic do_txn(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({name, " pre out_valid"}, out_valid, 1'b0);
        chk({name, " in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, " out_valid"}, out_valid, 1'b1);
        chk({name, " taken"}, taken, v.e_taken);
        chk({name, " next_pc"}, next_pc, v.e_npc);
        chk({name, " mispredict"}, mispredict, v.e_mis);
        chk({name, " illegal"}, illegal, v.e_ill);
        @(negedge clk);
        check_query({name, " rbw query"}, v.pc);
        @(posedge clk); #1;
        model_retire(v);
        chk({name, " retired out_valid"}, out_valid, 1'b0);
        check_stats(name);
    endtask

    initial begin
        vec_t a, b, c, d, t, n, u, t2;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; rs1 = '0; rs2 = '0; imm = '0; funct3 = '0; pred_in = 1'b0; query_pc = '0;
        model_reset();

        vecs[0]  = mk(3'b100, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h40, 0, 1, 32'h140, 1, 0);
        vecs[1]  = mk(3'b110, 32'h104, 32'hFFFFFFFF, 32'h1, 32'h40, 1, 0, 32'h108, 1, 0);
        vecs[2]  = mk(3'b101, 32'h108, 32'h7, 32'h7, 32'hFFFFFFF8, 1, 1, 32'h100, 0, 0);
        vecs[3]  = mk(3'b111, 32'h10C, 32'h0, 32'h1, 32'h10, 0, 0, 32'h110, 0, 0);
        vecs[4]  = mk(3'b001, 32'h110, 32'h5, 32'h5, 32'h20, 0, 0, 32'h114, 0, 0);
        vecs[5]  = mk(3'b000, 32'h114, 32'h5, 32'h6, 32'h20, 1, 0, 32'h118, 1, 0);
        vecs[6]  = mk(3'b100, 32'h118, 32'h1, 32'hFFFFFFFF, 32'h20, 0, 0, 32'h11C, 0, 0);
        vecs[7]  = mk(3'b111, 32'h11C, 32'hFFFFFFFF, 32'h1, 32'h4, 0, 1, 32'h120, 1, 0);
        vecs[8]  = mk(3'b010, 32'h120, 32'h0, 32'h0, 32'h40, 1, 0, 32'h124, 0, 1);
        vecs[9]  = mk(3'b011, 32'h124, 32'h0, 32'h0, 32'h40, 0, 0, 32'h128, 0, 1);
        vecs[10] = mk(3'b000, 32'hFFFFFFF0, 32'h0, 32'h0, 32'h20, 1, 1, 32'h10, 0, 0);
        vecs[11] = mk(3'b101, 32'h200, 32'h80000000, 32'h0, 32'h20, 0, 0, 32'h204, 0, 0);
        vecs[12] = mk(3'b110, 32'hFFFFFFFC, 32'h1, 32'h0, 32'h20, 0, 0, 32'h0, 0, 0);
        vecs[13] = mk(3'b000, 32'h120, 32'h1, 32'h1, 32'h8, 1, 1, 32'h128, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset taken", taken, 1'b0);
        chk("reset next_pc", next_pc, 32'h0);
        chk("reset mispredict", mispredict, 1'b0);
        chk("reset illegal", illegal, 1'b0);
        check_stats("reset");
        check_query("reset query 0x40", 32'h40);
        chk("reset query 0x40 const", query_taken, 1'b0);

        do_txn(mk(3'b000, 32'h40, 32'h5, 32'h5, 32'h10, 0, 1, 32'h50, 1, 0), "beq40");
        check_query("beq40 trained", 32'h40);
        chk("beq40 trained const", query_taken, 1'b1);
        chk("beq40 branches", stat_branches, 32'd1);
        chk("beq40 mispredicts", stat_mispredicts, 32'd1);

        for (int i = 0; i < 14; i++) do_txn(vecs[i], $sformatf("v%0d", i));
        for (int i = 0; i < 16; i++) check_query($sformatf("sweep idx%0d", i), 32'(i * 4));

        // Backpressure: A stalls for 5 cycles, then retires while B is accepted.
        a = mk(3'b001, 32'h80, 32'h1, 32'h2, 32'h8, 1, 1, 32'h88, 0, 0);
        b = mk(3'b000, 32'h90, 32'h3, 32'h4, 32'h10, 1, 0, 32'h94, 1, 0);
        @(negedge clk);
        drive(a); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        drive(b);
        chk("bp A out_valid", out_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d in_ready", k), in_ready, 1'b0);
            chk($sformatf("bp hold%0d out_valid", k), out_valid, 1'b1);
            chk($sformatf("bp hold%0d next_pc", k), next_pc, 32'h88);
            chk($sformatf("bp hold%0d taken", k), taken, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_retire(a);
        chk("bp B out_valid", out_valid, 1'b1);
        chk("bp B next_pc", next_pc, 32'h94);
        chk("bp B mispredict", mispredict, 1'b1);
        check_stats("bp A retired");
        @(posedge clk); #1;
        model_retire(b);
        chk("bp B retired out_valid", out_valid, 1'b0);
        check_stats("bp B retired");

        // Flush with a valid result and a competing request: neither survives.
        c = mk(3'b000, 32'h44, 32'h5, 32'h5, 32'h10, 0, 1, 32'h54, 1, 0);
        d = mk(3'b001, 32'h48, 32'h1, 32'h2, 32'h10, 0, 1, 32'h58, 1, 0);
        @(negedge clk);
        drive(c); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush C out_valid", out_valid, 1'b1);
        drive(d); flush = 1'b1;
        #1;
        chk("flush in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", out_valid, 1'b0);
        check_stats("flush");
        @(posedge clk); #1;
        chk("flush D dropped", out_valid, 1'b0);
        check_query("flush bht 0x44", 32'h44);
        check_query("flush bht 0x48", 32'h48);

        // Reset while a result is pending.
        t = mk(3'b000, 32'h20, 32'h1, 32'h1, 32'h8, 1, 1, 32'h28, 0, 0);
        @(negedge clk);
        drive(t); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midrst pending", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst out_valid", out_valid, 1'b0);
        check_stats("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        check_query("midrst bht idx8", 32'h20);

        // Saturation high then low.
        n  = mk(3'b001, 32'h20, 32'h1, 32'h1, 32'h8, 1, 0, 32'h24, 1, 0);
        u  = mk(3'b001, 32'h24, 32'h2, 32'h2, 32'h8, 0, 0, 32'h28, 0, 0);
        t2 = mk(3'b000, 32'h24, 32'h2, 32'h2, 32'h8, 0, 1, 32'h2C, 1, 0);
        for (int k = 0; k < 4; k++) do_txn(t, $sformatf("sat up%0d", k));
        check_query("sat at max", 32'h20);
        do_txn(n, "sat down1");
        check_query("sat 10", 32'h20);
        chk("sat 10 const", query_taken, 1'b1);
        do_txn(n, "sat down2");
        check_query("sat 01", 32'h20);
        chk("sat 01 const", query_taken, 1'b0);
        for (int k = 0; k < 3; k++) do_txn(u, $sformatf("sat low%0d", k));
        check_query("sat at zero", 32'h24);
        do_txn(t2, "sat rise1");
        check_query("sat rise1 q", 32'h24);
        chk("sat rise1 const", query_taken, 1'b0);
        do_txn(t2, "sat rise2");
        check_query("sat rise2 q", 32'h24);
        chk("sat rise2 const", query_taken, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
